// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg: op encodings, FSM states and XLEN-derived constants for the divide sequencer.
package div_seq_ctrl_pkg;
  localparam int DIV_XLEN = 32;
  localparam logic [DIV_XLEN-1:0] MOST_NEG = {1'b1, {(DIV_XLEN-1){1'b0}}};
  localparam logic [DIV_XLEN-1:0] ALL_ONES = {DIV_XLEN{1'b1}};
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: request/response handshake bundle between EX and the divide sequencer.
interface div_seq_ctrl_if
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;
  modport master (
    output req_valid_i, op_i, rs1_i, rs2_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, busy_o
  );
  modport slave (
    input  req_valid_i, op_i, rs1_i, rs2_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/div_seq_ctrl_div_step.sv
// div_step: one radix-2 restoring iteration -- shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [2*XLEN:0] sh;
  logic [XLEN:0]   diff;
  assign sh    = {rem_i, quo_i} << 1;
  assign diff  = sh[2*XLEN:XLEN] - {1'b0, dvs_i};
  assign rem_o = diff[XLEN] ? sh[2*XLEN:XLEN] : diff;
  assign quo_o = sh[XLEN-1:0] | {{(XLEN-1){1'b0}}, ~diff[XLEN]};
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV/DIVU/REM/REMU sequencer (radix-2 restoring, RISC-V corner cases).
// Define DIV_REM_FUSE_EN to answer a complementary DIV<->REM request from the last computed pair.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input logic           clk_i,
  input logic           rst_n_i,
  input logic           flush_i,
  div_seq_ctrl_if.slave bus
);
  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            s1_q, s1_d, s2_q, s2_d;
  logic [XLEN:0]   rem_q, rem_d, rem_n;
  logic [XLEN-1:0] quo_q, quo_d, quo_n, dvs_q, dvs_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            sgn, ovf, dz, acc, fin, hit;
  logic [XLEN-1:0] q_fix, r_fix, hit_val;
  assign sgn   = ~bus.op_i[0];
  assign dz    = bus.rs2_i == '0;
  assign ovf   = sgn && bus.rs1_i == MOST_NEG && bus.rs2_i == ALL_ONES;
  assign acc   = bus.req_valid_i && bus.req_ready_o;
  assign fin   = state_q == CALC && cnt_q == '0 && !flush_i;
  // Sign fix-up applied to the values coming out of the final iteration
  assign q_fix = (s1_q ^ s2_q) ? -quo_n : quo_n;
  assign r_fix = s1_q ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
  assign bus.req_ready_o  = state_q == IDLE && !flush_i;
  assign bus.resp_valid_o = state_q == DONE;
  assign bus.busy_o       = state_q != IDLE;
  assign bus.result_o     = res_q;
  div_step #(.XLEN(XLEN)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );
`ifdef DIV_REM_FUSE_EN
  logic            fv_q, fv_d, fsgn_q, fsgn_d, frem_q, frem_d;
  logic [XLEN-1:0] fa_q, fa_d, fb_q, fb_d, fquo_q, fquo_d, frv_q, frv_d;
  assign hit     = fv_q && fsgn_q == sgn && fa_q == bus.rs1_i && fb_q == bus.rs2_i && frem_q != bus.op_i[1];
  assign hit_val = bus.op_i[1] ? frv_q : fquo_q;
  // Entry is invalidated while a new CALC op runs and becomes valid when it completes
  always_comb begin
    fv_d   = fv_q;
    fsgn_d = fsgn_q;
    frem_d = frem_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    fquo_d = fquo_q;
    frv_d  = frv_q;
    if (flush_i) fv_d = 1'b0;
    else if (acc && !dz && !ovf && !hit) begin
      fv_d   = 1'b0;
      fsgn_d = sgn;
      fa_d   = bus.rs1_i;
      fb_d   = bus.rs2_i;
    end else if (fin) begin
      fv_d   = 1'b1;
      frem_d = op_q[1];
      fquo_d = q_fix;
      frv_d  = r_fix;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fv_q   <= 1'b0;
      fsgn_q <= 1'b0;
      frem_q <= 1'b0;
      fa_q   <= '0;
      fb_q   <= '0;
      fquo_q <= '0;
      frv_q  <= '0;
    end else begin
      fv_q   <= fv_d;
      fsgn_q <= fsgn_d;
      frem_q <= frem_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
      fquo_q <= fquo_d;
      frv_q  <= frv_d;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_val = '0;
`endif
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush_i) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (bus.req_valid_i) begin
        op_d    = bus.op_i;
        s1_d    = sgn & bus.rs1_i[XLEN-1];
        s2_d    = sgn & bus.rs2_i[XLEN-1];
        quo_d   = s1_d ? -bus.rs1_i : bus.rs1_i;
        dvs_d   = s2_d ? -bus.rs2_i : bus.rs2_i;
        rem_d   = '0;
        cnt_d   = CNT_W'(XLEN - 1);
        state_d = (dz || ovf || hit) ? DONE : CALC;
        res_d   = dz ? (bus.op_i[1] ? bus.rs1_i : ALL_ONES) :
                  ovf ? (bus.op_i[1] ? '0 : MOST_NEG) :
                  hit ? hit_val : res_q;
      end
    end else if (state_q == CALC) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        res_d   = op_q[1] ? r_fix : q_fix;
        state_d = DONE;
      end
    end else if (bus.resp_ready_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized + directed bench for div_seq_ctrl against an arithmetic reference model.
// Honors DIV_REM_FUSE_EN so expected latencies follow the build.
module tb_div_seq_ctrl;
  import div_seq_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  bit fv = 1'b0;
  bit fsgn, frem;
  logic [31:0] fa, fb;
`ifdef DIV_REM_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif
  always #5 clk = ~clk;
  div_seq_ctrl_if #(.XLEN(32)) bus ();
  div_seq_ctrl #(.XLEN(32)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      DIV_OP_DIV:  return sa / sb;
      DIV_OP_REM:  return sa % sb;
      DIV_OP_DIVU: return a / b;
      default:     return a % b;
    endcase
  endfunction
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    if (FUSE && fv && fsgn == !op[0] && fa == a && fb == b && frem != op[1]) return 1;
    return 33;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 100);
      2: return 32'h0;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return -$urandom_range(1, 100);
    endcase
  endfunction
  task automatic wait_resp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int el);
    int lat;
    lat = 1;
    while (!bus.resp_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0d %h/%h", op, a, b), lat, el);
    check($sformatf("result op%0d %h/%h", op, a, b), bus.result_o, ref_res(op, a, b));
    if (el == 33) begin
      fv = 1'b1; fsgn = !op[0]; fa = a; fb = b; frem = op[1];
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid_i = 1'b1;
    bus.op_i = op;
    bus.rs1_i = a;
    bus.rs2_i = b;
    check("req_ready_idle", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask
  task automatic ack();
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    check("resp_valid_after_ack", bus.resp_valid_o, 0);
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int el;
    el = exp_lat(op, a, b);
    issue(op, a, b);
    wait_resp(op, a, b, el);
    ack();
  endtask
  initial begin
    logic [1:0] op, pop;
    logic [31:0] a, b, pa, pb, held;
    int el, seen;
    bus.req_valid_i = 1'b0;
    bus.resp_ready_i = 1'b0;
    bus.op_i = 2'b00;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready_o, 1);
    check("rst_resp_valid", bus.resp_valid_o, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_busy", bus.busy_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(DIV_OP_DIVU, 100, 7);
    run(DIV_OP_REMU, 100, 7);
    run(DIV_OP_DIV, -7, 2);
    run(DIV_OP_REM, -7, 2);
    run(DIV_OP_REM, 7, -2);
    run(DIV_OP_DIV, 5, 0);
    run(DIV_OP_REMU, 5, 0);
    run(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run(DIV_OP_DIV, 1000, 33);
    run(DIV_OP_REM, 1000, 33);
    // back-pressure: result held, a waiting request is only taken after release
    el = exp_lat(DIV_OP_DIVU, 12345, 67);
    issue(DIV_OP_DIVU, 12345, 67);
    wait_resp(DIV_OP_DIVU, 12345, 67, el);
    held = bus.result_o;
    bus.req_valid_i = 1'b1;
    bus.op_i = DIV_OP_DIV;
    bus.rs1_i = -100;
    bus.rs2_i = 7;
    repeat (10) begin
      @(posedge clk); #1;
      check("hold_result", bus.result_o, held);
      check("hold_req_ready", bus.req_ready_o, 0);
      check("hold_resp_valid", bus.resp_valid_o, 1);
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    check("release_resp_valid", bus.resp_valid_o, 0);
    check("release_req_ready", bus.req_ready_o, 1);
    el = exp_lat(DIV_OP_DIV, -100, 7);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("release_accept_busy", bus.busy_o, 1);
    wait_resp(DIV_OP_DIV, -100, 7, el);
    ack();
    // flush during iteration 15, with a request presented in the flush cycle
    issue(DIV_OP_DIVU, 1000, 33);
    repeat (14) begin @(posedge clk); #1; end
    flush = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.op_i = DIV_OP_DIV;
    bus.rs1_i = 9;
    bus.rs2_i = 3;
    #1;
    check("flush_req_ready", bus.req_ready_o, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.req_valid_i = 1'b0;
    fv = 1'b0;
    check("flush_busy", bus.busy_o, 0);
    check("flush_resp_valid", bus.resp_valid_o, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen += int'(bus.resp_valid_o) + int'(bus.busy_o);
    end
    check("flush_quiet", seen, 0);
    run(DIV_OP_DIV, 1000, 33);
    run(DIV_OP_REM, 1000, 33);
    // asynchronous reset in the middle of CALC
    issue(DIV_OP_DIVU, 32'hDEAD_BEEF, 13);
    repeat (10) begin @(posedge clk); #1; end
    check("calc_busy", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    fv = 1'b0;
    check("arst_req_ready", bus.req_ready_o, 1);
    check("arst_resp_valid", bus.resp_valid_o, 0);
    check("arst_result", bus.result_o, 0);
    check("arst_busy", bus.busy_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(DIV_OP_REMU, 32'hDEAD_BEEF, 13);
    pa = 1; pb = 1; pop = 2'b00;
    for (int i = 0; i < 60; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        a = pa; b = pb; op = pop ^ 2'b10;
      end else begin
        op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
      end
      run(op, a, b);
      pa = a; pb = b; pop = op;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Multi-cycle sequencer for the M-extension divide path. It accepts DIV/DIVU/REM/REMU requests from EX over a valid/ready handshake. It runs a radix-2 restoring division, one quotient bit per cycle, and applies the RISC-V sign and corner-case rules. It returns a registered result that is held until EX accepts it. It replaces single-cycle combinational division and provides a clean stall source (busy_o) for the pipeline controller.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, $clog2(XLEN), iteration counter width.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; kills any in-flight or pending operation
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o at the clock edge
op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_i  in  XLEN  dividend
rs2_i  in  XLEN  divisor
resp_valid_o  out  1  result valid
resp_ready_i  in  1  consumer accepts the result
result_o  out  XLEN  quotient or remainder per op
busy_o  out  1  high in CALC or DONE; the pipeline stalls on it

Behaviour:
- Clock/reset: one clock, clk_i; reset is asynchronous, active-low (rst_n_i).
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, result_o=0, busy_o=0, counter=0, all datapath registers 0.
- FSM states are IDLE, CALC, DONE.
- IDLE: req_ready_o=1. On accept:
  - Latch op, the sign of each operand, and the operand magnitudes. Magnitudes are absolute values for DIV/REM and raw values for DIVU/REMU.
  - Load counter=XLEN-1.
  - If rs2_i==0: set result to all-ones for DIV/DIVU, or rs1_i for REM/REMU, and go to DONE.
  - Else if signed op and rs1_i==0x80000000 and rs2_i==0xFFFFFFFF: set result to 0x80000000 for DIV, or 0 for REM, and go to DONE.
  - Otherwise go to CALC.
- CALC: req_ready_o=0. Each cycle:
  - Shift {rem,quo} left by one.
  - Trial-subtract the divisor magnitude from the remainder; if the result is non-negative, keep it and set the quotient LSB.
  - Decrement the counter.
  - On the iteration with counter==0, apply the sign fix-up into result_o and go to DONE:
    - Quotient is negated if the signed operand signs differ.
    - Remainder takes the sign of the dividend.
- Latency: normal ops take XLEN+1 cycles from the accept edge to resp_valid_o high. Special cases take 1 cycle.
- DONE: resp_valid_o=1, and result_o is stable. On resp_ready_i, go to IDLE with resp_valid_o=0. A new request can be accepted on the next edge; there is no back-to-back accept in the same cycle.
- Back-pressure: DONE holds indefinitely while resp_ready_i=0.
- flush_i has priority over all other events:
  - In any state, the next state is IDLE and resp_valid_o drops.
  - A request presented in the same cycle as flush_i is not accepted; req_ready_o is forced to 0 during flush.
- Reset asserted mid-operation returns to reset values immediately; no partial result is visible.
- Width rules:
  - The remainder register is XLEN+1 bits for the trial subtract.
  - Negation is two's complement mod 2^XLEN.

Optional Feature:
DIV_REM_FUSE_EN.
- With the macro defined:
  - The last completed normal (CALC-path) operation's signedness, rs1, rs2, final quotient and final remainder are retained.
  - A new request with the same signedness and identical operands, but the complementary op (DIV↔REM, DIVU↔REMU), skips CALC. It enters DONE with the stored, sign-fixed value: 1-cycle latency.
  - flush_i and reset invalidate the stored entry.
- Without the macro: no storage; every non-special request takes XLEN+1 cycles.

Decomposition:
- Shared package holds:
  - Op encodings: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
  - FSM state typedef: IDLE/CALC/DONE.
  - XLEN-derived constants: the most-negative value and the all-ones value.
- One sub-module is natural: div_step. It is a combinational single-iteration shift/trial-subtract taking rem, quo and divisor, and returning the next rem and next quo. This keeps the iteration unit-testable.

Test Plan:
- DIVU 100/7 → resp_valid_o exactly 33 cycles after accept, result 14. Then REMU 100/7 → 2.
- DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7/-2 → 1.
- DIV 5/0 → 0xFFFFFFFF in 1 cycle. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Hold resp_ready_i=0 for 10 cycles in DONE → result_o stable, req_ready_o=0 throughout. Release → accept on the next edge.
- Assert flush_i at CALC iteration 15 → IDLE next cycle, no resp_valid_o. A request in the flush cycle is ignored. Drop rst_n_i mid-CALC → outputs go to reset values asynchronously.
- With DIV_REM_FUSE_EN: DIV 1000/33 (30), then REM 1000/33 → 10 with 1-cycle latency. Without the macro → 33 cycles.
